// File: rtl/regfile.sv
// rtl/regfile.sv - 32x32 architectural register file with per-register rename tags and commit bypass
module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        iclr,
  input  logic        iROB_nick_en,
  input  logic [4:0]  iROB_nick,
  input  logic [4:0]  iROB_nick_regnm,
  input  logic        iROB_cmt_en,
  input  logic [4:0]  iROB_cmt_regnm,
  input  logic [31:0] iROB_cmt_dt,
  input  logic [4:0]  iROB_cmt_nick,
  input  logic [4:0]  iDP_rs1_regnm,
  input  logic [4:0]  iDP_rs2_regnm,
  output logic [31:0] oDP_rs1_dt,
  output logic [4:0]  oDP_rs1_nick,
  output logic [31:0] oDP_rs2_dt,
  output logic [4:0]  oDP_rs2_nick
);

  localparam int NW = 5;
  localparam int KW = 5;
  localparam int DW = 32;
  localparam int NREG = 32;

  logic [DW-1:0] data [NREG];
  logic [KW-1:0] tag  [NREG];

  logic          rename_fire;
  logic          cmt_fire;
  logic          cmt_tag_match;
  logic [NW-1:0] rd_nm [2];
  logic [DW-1:0] rd_dt [2];
  logic [KW-1:0] rd_nk [2];

  // x0 is filtered here so nothing downstream ever touches entry 0
  assign rename_fire   = rdy && iROB_nick_en && (iROB_nick_regnm != '0);
  assign cmt_fire      = rdy && iROB_cmt_en && (iROB_cmt_regnm != '0);
  assign cmt_tag_match = (tag[iROB_cmt_regnm] == iROB_cmt_nick);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        data[i] <= '0;
        tag[i]  <= '0;
      end
    end else if (rdy) begin
      if (cmt_fire) begin
        data[iROB_cmt_regnm] <= iROB_cmt_dt;
      end
      for (int i = 1; i < NREG; i++) begin
        if (iclr) begin
          tag[i] <= '0;
        end else if (rename_fire && (iROB_nick_regnm == NW'(i))) begin
          tag[i] <= iROB_nick;
        end else if (cmt_fire && (iROB_cmt_regnm == NW'(i)) && cmt_tag_match) begin
          // only the producer the tag still points at may clear it
          tag[i] <= '0;
        end
      end
    end
  end

  assign rd_nm[0] = iDP_rs1_regnm;
  assign rd_nm[1] = iDP_rs2_regnm;

  // reads see pre-rename tags; a matching commit is forwarded as ready data
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_dt[p] = '0;
      rd_nk[p] = '0;
      if (!rst && (rd_nm[p] != '0)) begin
        if (cmt_fire && (iROB_cmt_regnm == rd_nm[p]) && cmt_tag_match) begin
          rd_dt[p] = iROB_cmt_dt;
        end else begin
          rd_dt[p] = data[rd_nm[p]];
          rd_nk[p] = tag[rd_nm[p]];
        end
      end
    end
  end

  assign oDP_rs1_dt   = rd_dt[0];
  assign oDP_rs1_nick = rd_nk[0];
  assign oDP_rs2_dt   = rd_dt[1];
  assign oDP_rs2_nick = rd_nk[1];

endmodule

// File: tb/tb_regfile.sv
// tb/tb_regfile.sv - table-driven self-checking bench for regfile
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst, rdy, iclr;
  logic        iROB_nick_en;
  logic [4:0]  iROB_nick, iROB_nick_regnm;
  logic        iROB_cmt_en;
  logic [4:0]  iROB_cmt_regnm;
  logic [31:0] iROB_cmt_dt;
  logic [4:0]  iROB_cmt_nick;
  logic [4:0]  iDP_rs1_regnm, iDP_rs2_regnm;
  logic [31:0] oDP_rs1_dt, oDP_rs2_dt;
  logic [4:0]  oDP_rs1_nick, oDP_rs2_nick;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile dut (
    .clk(clk), .rst(rst), .rdy(rdy), .iclr(iclr),
    .iROB_nick_en(iROB_nick_en), .iROB_nick(iROB_nick), .iROB_nick_regnm(iROB_nick_regnm),
    .iROB_cmt_en(iROB_cmt_en), .iROB_cmt_regnm(iROB_cmt_regnm), .iROB_cmt_dt(iROB_cmt_dt),
    .iROB_cmt_nick(iROB_cmt_nick),
    .iDP_rs1_regnm(iDP_rs1_regnm), .iDP_rs2_regnm(iDP_rs2_regnm),
    .oDP_rs1_dt(oDP_rs1_dt), .oDP_rs1_nick(oDP_rs1_nick),
    .oDP_rs2_dt(oDP_rs2_dt), .oDP_rs2_nick(oDP_rs2_nick)
  );

  typedef struct {
    logic        rst, rdy, clr;
    logic        nen;
    logic [4:0]  nick, nreg;
    logic        cen;
    logic [4:0]  creg;
    logic [31:0] cdt;
    logic [4:0]  cnick;
    logic [4:0]  rs1, rs2;
    logic [31:0] e_dt1;
    logic [4:0]  e_nk1;
    logic [31:0] e_dt2;
    logic [4:0]  e_nk2;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic y, logic c, logic ne, logic [4:0] nk, logic [4:0] nr,
                              logic ce, logic [4:0] cr, logic [31:0] cd, logic [4:0] cn,
                              logic [4:0] s1, logic [4:0] s2,
                              logic [31:0] d1, logic [4:0] k1, logic [31:0] d2, logic [4:0] k2);
    vec_t v;
    v.rst = r; v.rdy = y; v.clr = c; v.nen = ne; v.nick = nk; v.nreg = nr;
    v.cen = ce; v.creg = cr; v.cdt = cd; v.cnick = cn; v.rs1 = s1; v.rs2 = s2;
    v.e_dt1 = d1; v.e_nk1 = k1; v.e_dt2 = d2; v.e_nk2 = k2;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; rdy = 1'b1; iclr = 1'b0;
    iROB_nick_en = 1'b0; iROB_nick = '0; iROB_nick_regnm = '0;
    iROB_cmt_en = 1'b0; iROB_cmt_regnm = '0; iROB_cmt_dt = '0; iROB_cmt_nick = '0;
    iDP_rs1_regnm = '0; iDP_rs2_regnm = '0;
  endtask

  task automatic read_all_zero(string tagname);
    for (int r = 0; r < 32; r += 2) begin
      iDP_rs1_regnm = 5'(r);
      iDP_rs2_regnm = 5'(r + 1);
      #1;
      check($sformatf("%s_x%0d_dt", tagname, r), oDP_rs1_dt, 32'h0);
      check($sformatf("%s_x%0d_nick", tagname, r), 32'(oDP_rs1_nick), 32'h0);
      check($sformatf("%s_x%0d_dt", tagname, r + 1), oDP_rs2_dt, 32'h0);
      check($sformatf("%s_x%0d_nick", tagname, r + 1), 32'(oDP_rs2_nick), 32'h0);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    read_all_zero("reset");

    //        rst  rdy  clr  nen nick nreg cen creg cdt           cnick rs1 rs2  e_dt1        k1 e_dt2        k2
    vecs.push_back(mk(0, 1, 0, 1, 5,  0,  0, 0,  32'h0,        0,  0,  0,  32'h0,        0, 32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  0,  0, 0,  32'h0,        0,  0,  3,  32'h0,        0, 32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 1, 7,  3,  0, 0,  32'h0,        0,  3,  0,  32'h0,        0, 32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  0,  0, 0,  32'h0,        0,  3,  0,  32'h0,        7, 32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  0,  1, 3,  32'hDEADBEEF, 7,  3,  4,  32'hDEADBEEF, 0, 32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  0,  0, 0,  32'h0,        0,  3,  3,  32'hDEADBEEF, 0, 32'hDEADBEEF, 0));
    vecs.push_back(mk(0, 1, 0, 1, 7,  3,  0, 0,  32'h0,        0,  3,  0,  32'hDEADBEEF, 0, 32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 1, 9,  3,  0, 0,  32'h0,        0,  3,  0,  32'hDEADBEEF, 7, 32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  0,  1, 3,  32'h11,       7,  3,  0,  32'hDEADBEEF, 9, 32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  0,  0, 0,  32'h0,        0,  3,  0,  32'h11,       9, 32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 1, 2,  5,  0, 0,  32'h0,        0,  5,  0,  32'h0,        0, 32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 1, 4,  5,  1, 5,  32'h22,       2,  5,  3,  32'h22,       0, 32'h11,       9));
    vecs.push_back(mk(0, 1, 0, 0, 0,  0,  0, 0,  32'h0,        0,  5,  0,  32'h22,       4, 32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 1, 10, 1,  0, 0,  32'h0,        0,  0,  0,  32'h0,        0, 32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 1, 11, 2,  0, 0,  32'h0,        0,  0,  0,  32'h0,        0, 32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 1, 12, 31, 0, 0,  32'h0,        0,  1,  2,  32'h0,       10, 32'h0,       11));
    // flush paired with the branch's own commit and a discarded rename
    vecs.push_back(mk(0, 1, 1, 1, 13, 6,  1, 1,  32'h55,      10,  1,  31, 32'h55,       0, 32'h0,       12));
    vecs.push_back(mk(0, 1, 0, 0, 0,  0,  0, 0,  32'h0,        0,  1,  2,  32'h55,       0, 32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  0,  0, 0,  32'h0,        0,  31, 6,  32'h0,        0, 32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  0,  0, 0,  32'h0,        0,  3,  5,  32'h11,       0, 32'h22,       0));
    vecs.push_back(mk(0, 1, 0, 1, 3,  7,  0, 0,  32'h0,        0,  7,  0,  32'h0,        0, 32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  0,  0, 0,  32'h0,        0,  7,  0,  32'h0,        3, 32'h0,        0));
    // rdy low: nothing lands, no bypass
    vecs.push_back(mk(0, 0, 0, 1, 6,  8,  1, 7,  32'h77,       3,  7,  8,  32'h0,        3, 32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  0,  0, 0,  32'h0,        0,  7,  8,  32'h0,        3, 32'h0,        0));
    vecs.push_back(mk(0, 0, 1, 0, 0,  0,  0, 0,  32'h0,        0,  7,  0,  32'h0,        3, 32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  0,  0, 0,  32'h0,        0,  7,  3,  32'h0,        3, 32'h11,       0));
    vecs.push_back(mk(0, 1, 0, 1, 5,  0,  1, 0,  32'hFFFF,     0,  0,  0,  32'h0,        0, 32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  0,  0, 0,  32'h0,        0,  0,  5,  32'h0,        0, 32'h22,       0));
    // reset mid-stream forces reads to zero
    vecs.push_back(mk(1, 1, 0, 1, 8,  9,  1, 3,  32'h99,       0,  3,  7,  32'h0,        0, 32'h0,        0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      rst = vecs[i].rst; rdy = vecs[i].rdy; iclr = vecs[i].clr;
      iROB_nick_en = vecs[i].nen; iROB_nick = vecs[i].nick; iROB_nick_regnm = vecs[i].nreg;
      iROB_cmt_en = vecs[i].cen; iROB_cmt_regnm = vecs[i].creg;
      iROB_cmt_dt = vecs[i].cdt; iROB_cmt_nick = vecs[i].cnick;
      iDP_rs1_regnm = vecs[i].rs1; iDP_rs2_regnm = vecs[i].rs2;
      #3;
      check($sformatf("v%0d_rs1_dt", i), oDP_rs1_dt, vecs[i].e_dt1);
      check($sformatf("v%0d_rs1_nick", i), 32'(oDP_rs1_nick), 32'(vecs[i].e_nk1));
      check($sformatf("v%0d_rs2_dt", i), oDP_rs2_dt, vecs[i].e_dt2);
      check($sformatf("v%0d_rs2_nick", i), 32'(oDP_rs2_nick), 32'(vecs[i].e_nk2));
    end

    @(posedge clk);
    #1 idle_inputs();
    read_all_zero("midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile.md
# regfile

Architectural register file with rename tags, directly downstream of the reorder buffer. It holds 32 × 32-bit integer registers plus a 5-bit rename tag ("nick") per register. The ROB uses it to tag destination registers at issue, to write committed results back, and to drop all pending tags on a mispredict flush. Dispatch reads two source operands per cycle, and each read returns either a ready value or the nick of the ROB entry that will produce it.

## Interface
Parameters: none. Widths come from `config.v`: `NameBus` is 5 bits, `NickBus` is 5 bits, `DataBus` is 32 bits. Nick 0 means "no pending producer"; valid nicks are 1..31.

Ports:
- clk  in  1  system clock, all state changes on posedge
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; when low, no state changes
- iclr  in  1  flush from ROB (mispredicted branch commit)
- iROB_nick_en  in  1  rename request valid
- iROB_nick  in  NickBus  nick to attach
- iROB_nick_regnm  in  NameBus  destination register being renamed
- iROB_cmt_en  in  1  commit write valid
- iROB_cmt_regnm  in  NameBus  committed destination register
- iROB_cmt_dt  in  DataBus  committed value
- iROB_cmt_nick  in  NickBus  nick of the committing entry
- iDP_rs1_regnm  in  NameBus  source register 1 index
- iDP_rs2_regnm  in  NameBus  source register 2 index
- oDP_rs1_dt  out  DataBus  rs1 value (valid when oDP_rs1_nick==0)
- oDP_rs1_nick  out  NickBus  rs1 pending producer, 0 if ready
- oDP_rs2_dt  out  DataBus  rs2 value
- oDP_rs2_nick  out  NickBus  rs2 pending producer

## Operation
- State: data[0..31] and tag[0..31]. Reset clears every data and tag entry to 0.
- Register x0:
  - Never written and never tagged. Rename or commit requests with regnm==0 are ignored.
  - Reads of x0 always return dt=0, nick=0.
- Rename: when `iROB_nick_en` is set and regnm≠0, `tag[regnm] <= iROB_nick`.
- Commit: when `iROB_cmt_en` is set and regnm≠0:
  - `data[regnm] <= iROB_cmt_dt` is unconditional, because in-order commit is architectural.
  - `tag[regnm] <= 0` only if `tag[regnm]==iROB_cmt_nick`. A younger rename is left intact.
- Same-cycle rename and commit to the same register: the data write happens, and the tag takes the new rename nick. Rename wins.
- Flush: `iclr` high at posedge sets all tags to 0 and discards any rename that cycle. A commit in the same cycle still writes its data, since the ROB pairs the flush with the branch's own write-back.
- Priority at posedge: rst > iclr (tags) > rename > commit tag clear. Data writes are blocked only by rst or `rdy` low.
- `rdy` low: all state holds; read outputs stay live.
- Read path (combinational, per port):
  - If regnm==0: dt=0, nick=0.
  - Else, if a commit is active this cycle with matching regnm and `tag[regnm]==iROB_cmt_nick`: forward dt=`iROB_cmt_dt`, nick=0.
  - Else: dt=`data[regnm]`, nick=`tag[regnm]`.
- A same-cycle rename never affects the reads of that cycle. Sources see the pre-rename tag, which is correct for an instruction whose rd equals its rs.
- While rst is high, all read outputs are forced to 0.

## Timing
- Rename, commit and flush take effect at the posedge where they are sampled. They are visible on the read ports the following cycle.
- Commit bypass gives zero-cycle visibility of committed data on the read ports.
- Read latency is 0 cycles, purely combinational from regnm. Dispatch samples the result in its own cycle.
- No handshake and no backpressure: every request is accepted in the cycle it is presented.
- Up to one rename and one commit per cycle, plus two reads.

## Test plan
- Reset, then read all 32 registers → every read returns dt=0, nick=0. Rename x0 with nick 5, then read x0 → nick 0.
- Rename x3 with nick 7; next cycle read x3 → nick=7. Commit x3 with nick 7 and dt=0xDEADBEEF → the same-cycle read returns dt=0xDEADBEEF, nick=0; the next cycle gives the same result from storage.
- Rename x3 with nick 7, then rename x3 with nick 9, then commit nick 7 with dt=0x11 → data[x3]=0x11 and tag stays 9; a read returns nick 9.
- Same-cycle rename of x5 with nick 4 and commit of x5 (nick 2, tag 2) with dt=0x22 → the read that cycle returns 0x22/nick 0; the next cycle returns nick 4, and data=0x22.
- Tag x1, x2 and x31; assert `iclr` with a simultaneous commit of x1 (dt=0x55) and a rename of x6 → all tags read 0, data[x1]=0x55, and x6 is untagged.
- Hold `rdy` low while presenting rename and commit → no state change. Assert rst mid-stream with tags set → all data and tags are 0 the next cycle.
